// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants for the interrupt request controller
// Contents: default channel count, debounce lengths for simulation and board,
// and the channel index assigned to each board button.
package irq_pkg;

  localparam int N_IRQ_DEF            = 3;
  localparam int DEBOUNCE_CYCLES_SIM   = 4;
  localparam int DEBOUNCE_CYCLES_BOARD = 50000;
  localparam int CNT_WIDTH_DEF        = 16;

  // Button-to-IRQ mapping: btn[CH_x] raises irq[CH_x].
  localparam int CH_BTN0 = 0;
  localparam int CH_BTN1 = 1;
  localparam int CH_BTN2 = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-channel synchroniser, debouncer and rise detector
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   db         : debounced level (registered)
//   rise       : one-cycle pulse on a debounced 0->1 transition
module btn_debounce
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic                 db_q;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      // The counter only advances while s2 disagrees with db; any return to
      // the accepted level restarts the stability window.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign rise = db & ~db_q;

endmodule

// File: rtl/irq_request_ctrl.sv
// rtl/irq_request_ctrl.sv - buttons to held interrupt requests with CPU acknowledge
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button levels, one per channel
//   en         : per-channel enable for latching new edges
//   irw        : CPU acknowledge, clears the pending request on that line
//   irq        : held interrupt request
//   ovr        : sticky overrun, an edge arrived while irq was already pending
//   db_level   : debounced button levels
module irq_request_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ           = N_IRQ_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] btn,
  input  logic [N_IRQ-1:0] en,
  input  logic [N_IRQ-1:0] irw,
  output logic [N_IRQ-1:0] irq,
  output logic [N_IRQ-1:0] ovr,
  output logic [N_IRQ-1:0] db_level
);

  logic [N_IRQ-1:0] db;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] acc;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .db   (db[i]),
      .rise (rise[i])
    );
  end

  assign acc = rise & en;

  // A new edge coinciding with an ack re-arms the line: the ack retires the
  // old request and the new one takes its place, so it is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= '0;
      ovr <= '0;
    end else begin
      irq <= acc | (irq & ~irw);
      ovr <= ~irw & (ovr | (acc & irq));
    end
  end

  assign db_level = db;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// tb/tb_irq_request_ctrl.sv - directed table-driven bench for irq_request_ctrl
module tb_irq_request_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic [2:0] en;
  logic [2:0] irw;
  logic [2:0] irq;
  logic [2:0] ovr;
  logic [2:0] db_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] btn;
    logic [2:0] en;
    logic [2:0] irw;
    int         cycles;
    logic [2:0] e_irq;
    logic [2:0] e_ovr;
    logic [2:0] e_db;
  } vec_t;

  vec_t vecs[$];

  irq_request_ctrl #(
    .N_IRQ          (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .en      (en),
    .irw     (irw),
    .irq     (irq),
    .ovr     (ovr),
    .db_level(db_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] b, input logic [2:0] e, input logic [2:0] w,
                     input int n, input logic [2:0] xi, input logic [2:0] xo,
                     input logic [2:0] xd);
    vec_t v;
    v.btn = b; v.en = e; v.irw = w; v.cycles = n;
    v.e_irq = xi; v.e_ovr = xo; v.e_db = xd;
    vecs.push_back(v);
  endtask

  // Inputs already applied; the first edge is the one that samples btn.
  task automatic run_latency(input string tag, input logic [2:0] m);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("%s_irq_e%0d", tag, k), irq, (k == 6) ? m : 3'b000);
      chk($sformatf("%s_db_e%0d", tag, k), db_level, (k >= 5) ? m : 3'b000);
    end
  endtask

  initial begin
    // btn, en, irw, cycles, exp irq, exp ovr, exp db
    add(3'b001, 3'b111, 3'b000, 3, 3'b000, 3'b000, 3'b000); // 3-cycle glitch
    add(3'b000, 3'b111, 3'b000, 6, 3'b000, 3'b000, 3'b000);
    add(3'b001, 3'b111, 3'b000, 4, 3'b000, 3'b000, 3'b000); // 4-cycle pulse
    add(3'b000, 3'b111, 3'b000, 3, 3'b001, 3'b000, 3'b001);
    add(3'b000, 3'b111, 3'b000, 6, 3'b001, 3'b000, 3'b000);
    add(3'b110, 3'b111, 3'b000, 7, 3'b111, 3'b000, 3'b110); // ch1+ch2 together
    add(3'b110, 3'b111, 3'b010, 1, 3'b101, 3'b000, 3'b110); // ack ch1
    add(3'b110, 3'b111, 3'b000, 1, 3'b101, 3'b000, 3'b110);
    add(3'b110, 3'b111, 3'b010, 1, 3'b101, 3'b000, 3'b110); // ack idle line
    add(3'b010, 3'b111, 3'b000, 6, 3'b101, 3'b000, 3'b010); // release ch2
    add(3'b110, 3'b111, 3'b000, 7, 3'b101, 3'b100, 3'b110); // re-press: overrun
    add(3'b110, 3'b111, 3'b100, 1, 3'b001, 3'b000, 3'b110); // ack clears both
    add(3'b100, 3'b101, 3'b000, 6, 3'b001, 3'b000, 3'b100); // ch1 released, disabled
    add(3'b110, 3'b101, 3'b000, 8, 3'b001, 3'b000, 3'b110); // press while disabled
    add(3'b110, 3'b111, 3'b000, 2, 3'b001, 3'b000, 3'b110); // re-enable: no late edge
    add(3'b110, 3'b111, 3'b001, 1, 3'b000, 3'b000, 3'b110);
    add(3'b111, 3'b111, 3'b000, 7, 3'b001, 3'b000, 3'b111); // ch0 pending
    add(3'b110, 3'b111, 3'b000, 6, 3'b001, 3'b000, 3'b110);
    add(3'b111, 3'b111, 3'b000, 6, 3'b001, 3'b000, 3'b111); // rise is next edge
    add(3'b111, 3'b111, 3'b001, 1, 3'b001, 3'b000, 3'b111); // collision
    add(3'b111, 3'b111, 3'b000, 1, 3'b001, 3'b000, 3'b111);
    add(3'b111, 3'b111, 3'b001, 1, 3'b000, 3'b000, 3'b111);

    // Reset held with buttons pressed.
    rst_n = 1'b0; btn = 3'b111; en = 3'b111; irw = 3'b000;
    repeat (3) tick();
    chk("rst_irq", irq, 3'b000);
    chk("rst_ovr", ovr, 3'b000);
    chk("rst_db", db_level, 3'b000);
    rst_n = 1'b1;
    run_latency("rel", 3'b111);

    // Clean restart for the vector table.
    rst_n = 1'b0; btn = 3'b000;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("clean_irq", irq, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      btn = vecs[i].btn; en = vecs[i].en; irw = vecs[i].irw;
      repeat (vecs[i].cycles) tick();
      chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
      chk($sformatf("vec%0d_ovr", i), ovr, vecs[i].e_ovr);
      chk($sformatf("vec%0d_db", i), db_level, vecs[i].e_db);
    end
    irw = 3'b000;

    // Async reset in the middle of a debounce window.
    rst_n = 1'b0; btn = 3'b000;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    btn = 3'b001;
    repeat (4) tick();
    chk("mid_db_before", db_level, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_irq", irq, 3'b000);
    chk("mid_async_db", db_level, 3'b000);
    repeat (2) tick();
    rst_n = 1'b1;
    run_latency("mid", 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
